// File: rtl/tick_period_monitor_if.sv
// Slow-clock monitor bundle: slow clock and fault clear in, edge/period/lock/fault status out.
// master drives the slow clock side; slave is the monitor itself.
interface tick_period_monitor_if #(
    parameter int CNT_W = 26
);
    logic             slow_clk;
    logic             clear_faults;
    logic             edge_pulse;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             fault_fast;
    logic             fault_slow;
    logic             fault_stuck;

    modport master (
        output slow_clk, clear_faults,
        input  edge_pulse, period, period_valid, locked,
        input  fault_fast, fault_slow, fault_stuck
    );

    modport slave (
        input  slow_clk, clear_faults,
        output edge_pulse, period, period_valid, locked,
        output fault_fast, fault_slow, fault_stuck
    );
endinterface

// File: rtl/tick_period_monitor.sv
// Measures each slow_clk period in clk_in cycles, tracks lock and sticky fast/slow/stuck faults.
// Strobes land 3 cycles after slow_clk is first sampled high; status-only outputs, no backpressure.
module tick_period_monitor #(
    parameter int EXPECTED = 12_500_000,
    parameter int TOL      = 125_000,
    parameter int LOCK_N   = 4,
    parameter int CNT_W    = 26
) (
    input logic                  clk_in,
    input logic                  reset,
    tick_period_monitor_if.slave mon
);

    localparam logic [CNT_W-1:0] WIN_LO  = CNT_W'(EXPECTED - TOL);
    localparam logic [CNT_W-1:0] WIN_HI  = CNT_W'(EXPECTED + TOL);
    localparam logic [CNT_W-1:0] TMO     = CNT_W'(2 * EXPECTED);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam int               GW      = $clog2(LOCK_N + 1);
    localparam logic [GW-1:0]    GOOD_MAX = GW'(LOCK_N);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             s1_q, s2_q, s3_q, rise_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GW-1:0]    good_q, good_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             edge_q, edge_d;
    logic             pvld_q, pvld_d;
    logic             fast_q, fast_d;
    logic             slow_q, slow_d;
    logic             stuck_q, stuck_d;
    logic             set_fast, set_slow, set_stuck;

    // Two-flop synchronizer plus history flop; the edge is registered once more
    // so every status output moves on the same clk_in edge.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            s1_q   <= mon.slow_clk;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            rise_q <= s2_q & ~s3_q;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            good_q   <= '0;
            period_q <= '0;
            edge_q   <= 1'b0;
            pvld_q   <= 1'b0;
            fast_q   <= 1'b0;
            slow_q   <= 1'b0;
            stuck_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            good_q   <= good_d;
            period_q <= period_d;
            edge_q   <= edge_d;
            pvld_q   <= pvld_d;
            fast_q   <= fast_d;
            slow_q   <= slow_d;
            stuck_q  <= stuck_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        good_d    = good_q;
        period_d  = period_q;
        edge_d    = 1'b0;
        pvld_d    = 1'b0;
        set_fast  = 1'b0;
        set_slow  = 1'b0;
        set_stuck = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                good_d = '0;
                // First edge only starts the measurement; there is no period yet.
                if (rise_q) begin
                    edge_d  = 1'b1;
                    cnt_d   = CNT_ONE;
                    state_d = ARMED;
                end
            end
            ARMED, LOCKED: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                if (rise_q) begin
                    edge_d   = 1'b1;
                    pvld_d   = 1'b1;
                    period_d = cnt_q;
                    cnt_d    = CNT_ONE;
                    if (cnt_q < WIN_LO) begin
                        set_fast = 1'b1;
                        good_d   = '0;
                        state_d  = ARMED;
                    end else if (cnt_q > WIN_HI) begin
                        set_slow = 1'b1;
                        good_d   = '0;
                        state_d  = ARMED;
                    end else begin
                        good_d = (good_q == GOOD_MAX) ? good_q : good_q + 1'b1;
                        if (good_d == GOOD_MAX) begin
                            state_d = LOCKED;
                        end
                    end
                end else if (cnt_q >= TMO) begin
                    set_stuck = 1'b1;
                    good_d    = '0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                good_d  = '0;
            end
        endcase

        // A fault raised in the same cycle as clear_faults survives the clear.
        fast_d  = set_fast  | (fast_q  & ~mon.clear_faults);
        slow_d  = set_slow  | (slow_q  & ~mon.clear_faults);
        stuck_d = set_stuck | (stuck_q & ~mon.clear_faults);
    end

    assign mon.edge_pulse   = edge_q;
    assign mon.period_valid = pvld_q;
    assign mon.period       = period_q;
    assign mon.locked       = (state_q == LOCKED);
    assign mon.fault_fast   = fast_q;
    assign mon.fault_slow   = slow_q;
    assign mon.fault_stuck  = stuck_q;

endmodule

// File: tb/tb_tick_period_monitor.sv
// Directed bench for tick_period_monitor with EXPECTED=100, TOL=5, LOCK_N=4, CNT_W=8.
// Each table row is one slow_clk rising edge plus the status expected at its strobe.
module tb_tick_period_monitor;

    localparam int EXPECTED = 100;
    localparam int TOL      = 5;
    localparam int LOCK_N   = 4;
    localparam int CNT_W    = 8;
    localparam int NVEC     = 30;

    typedef struct {
        int   gap;
        logic clr;
        logic pv;
        int   per;
        logic lk;
        logic ff;
        logic fs;
        logic fst;
    } vec_t;

    logic clk_in = 1'b0;
    logic reset;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    vec_t vecs [NVEC];

    tick_period_monitor_if #(.CNT_W(CNT_W)) mon_if ();

    tick_period_monitor #(
        .EXPECTED (EXPECTED),
        .TOL      (TOL),
        .LOCK_N   (LOCK_N),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .mon    (mon_if)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic vec_t mk(input int gap, input logic clr, input logic pv, input int per,
                                input logic lk, input logic ff, input logic fs, input logic fst);
        vec_t v;
        v.gap = gap; v.clr = clr; v.pv = pv; v.per = per;
        v.lk = lk; v.ff = ff; v.fs = fs; v.fst = fst;
        return v;
    endfunction

    function automatic int any_out();
        return int'(mon_if.edge_pulse) + int'(mon_if.period_valid) + int'(mon_if.period)
             + int'(mon_if.locked) + int'(mon_if.fault_fast) + int'(mon_if.fault_slow)
             + int'(mon_if.fault_stuck);
    endfunction

    // Raise slow_clk, check the strobe 4 ticks later, then idle out the rest of the gap.
    task automatic do_edge(input int idx);
        vec_t  v;
        int    spur;
        string tag;
        v    = vecs[idx];
        spur = 0;
        tag  = $sformatf("e%0d", idx + 1);
        mon_if.slow_clk = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (i == 1) mon_if.slow_clk = 1'b0;
            spur += int'(mon_if.edge_pulse | mon_if.period_valid);
        end
        mon_if.clear_faults = v.clr;
        tick(1);
        mon_if.clear_faults = 1'b0;
        chk({tag, "_edge_pulse"},   int'(mon_if.edge_pulse),   1);
        chk({tag, "_period_valid"}, int'(mon_if.period_valid), int'(v.pv));
        chk({tag, "_period"},       int'(mon_if.period),       v.per);
        chk({tag, "_locked"},       int'(mon_if.locked),       int'(v.lk));
        chk({tag, "_fault_fast"},   int'(mon_if.fault_fast),   int'(v.ff));
        chk({tag, "_fault_slow"},   int'(mon_if.fault_slow),   int'(v.fs));
        chk({tag, "_fault_stuck"},  int'(mon_if.fault_stuck),  int'(v.fst));
        for (int i = 4; i < v.gap; i++) begin
            tick(1);
            spur += int'(mon_if.edge_pulse | mon_if.period_valid);
        end
        chk({tag, "_no_extra_strobe"}, spur, 0);
    endtask

    initial begin
        int bad;

        //            gap  clr pv per  lk ff fs st
        vecs[0]  = mk(100, 0, 0,   0, 0, 0, 0, 0);
        vecs[1]  = mk(100, 0, 1, 100, 0, 0, 0, 0);
        vecs[2]  = mk(100, 0, 1, 100, 0, 0, 0, 0);
        vecs[3]  = mk(100, 0, 1, 100, 0, 0, 0, 0);
        vecs[4]  = mk(100, 0, 1, 100, 1, 0, 0, 0);
        vecs[5]  = mk( 95, 0, 1, 100, 1, 0, 0, 0);
        vecs[6]  = mk(105, 0, 1,  95, 1, 0, 0, 0);
        vecs[7]  = mk( 94, 0, 1, 105, 1, 0, 0, 0);
        vecs[8]  = mk(100, 0, 1,  94, 0, 1, 0, 0);
        vecs[9]  = mk(100, 0, 1, 100, 0, 1, 0, 0);
        vecs[10] = mk(100, 0, 1, 100, 0, 1, 0, 0);
        vecs[11] = mk(100, 0, 1, 100, 0, 1, 0, 0);
        vecs[12] = mk(106, 0, 1, 100, 1, 1, 0, 0);
        vecs[13] = mk(100, 0, 1, 106, 0, 1, 1, 0);
        vecs[14] = mk(100, 1, 1, 100, 0, 0, 0, 0);
        vecs[15] = mk(100, 0, 1, 100, 0, 0, 0, 0);
        vecs[16] = mk(100, 0, 1, 100, 0, 0, 0, 0);
        vecs[17] = mk(  4, 0, 1, 100, 1, 0, 0, 0);
        vecs[18] = mk(100, 0, 0, 100, 0, 0, 0, 1);
        vecs[19] = mk( 50, 1, 1, 100, 0, 0, 0, 0);
        vecs[20] = mk(100, 1, 1,  50, 0, 1, 0, 0);
        vecs[21] = mk(100, 0, 1, 100, 0, 1, 0, 0);
        vecs[22] = mk(100, 0, 1, 100, 0, 1, 0, 0);
        vecs[23] = mk(100, 0, 1, 100, 0, 1, 0, 0);
        vecs[24] = mk( 50, 0, 1, 100, 1, 1, 0, 0);
        vecs[25] = mk(100, 0, 0,   0, 0, 0, 0, 0);
        vecs[26] = mk(100, 0, 1, 100, 0, 0, 0, 0);
        vecs[27] = mk(100, 0, 1, 100, 0, 0, 0, 0);
        vecs[28] = mk(100, 0, 1, 100, 0, 0, 0, 0);
        vecs[29] = mk(100, 0, 1, 100, 1, 0, 0, 0);

        reset = 1'b1;
        mon_if.slow_clk = 1'b0;
        mon_if.clear_faults = 1'b0;
        #2 reset = 1'b0;

        // Reset held while slow_clk toggles: nothing may move.
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            mon_if.slow_clk = ((i / 2) % 2) == 1;
            tick(1);
            bad += (any_out() != 0) ? 1 : 0;
        end
        chk("reset_hold_outputs", bad, 0);
        chk("reset_locked", int'(mon_if.locked), 0);
        chk("reset_period", int'(mon_if.period), 0);
        mon_if.slow_clk = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(3);

        // Steady lock, window edges, fast and slow faults, clear, relock.
        for (int i = 0; i <= 17; i++) do_edge(i);

        // slow_clk frozen after lock: stuck exactly 200 cycles after the last strobe.
        tick(199);
        chk("stuck_early_flag",   int'(mon_if.fault_stuck), 0);
        chk("stuck_early_locked", int'(mon_if.locked),      1);
        tick(1);
        chk("stuck_flag",   int'(mon_if.fault_stuck), 1);
        chk("stuck_locked", int'(mon_if.locked),      0);

        // Restart after stuck, clear vs. simultaneous fast fault, relock.
        for (int i = 18; i <= 24; i++) do_edge(i);

        // Asynchronous reset mid-period while locked.
        #2 reset = 1'b0;
        #1;
        chk("midreset_locked",     int'(mon_if.locked),     0);
        chk("midreset_fault_fast", int'(mon_if.fault_fast), 0);
        chk("midreset_period",     int'(mon_if.period),     0);
        chk("midreset_all_zero",   any_out(),               0);
        tick(2);
        reset = 1'b1;
        tick(2);

        for (int i = 25; i < NVEC; i++) do_edge(i);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
